// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR control sequencer.
// Saturation bounds are used only when FIR_CTRL_SAT_EN is defined.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_OUT_W  = 11;

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

endpackage

// File: rtl/fir_out_sat.sv
// Combinational clamp of a signed filter result to [SAT_MIN, SAT_MAX],
// sign-extended back to OUT_W. Instantiated only under FIR_CTRL_SAT_EN.
module fir_out_sat
    import fir_ctrl_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [OUT_W-1:0] y_i,
    output logic [OUT_W-1:0] y_o,
    output logic             sat_o
);

    localparam logic signed [OUT_W-1:0] MAX_V = OUT_W'(SAT_MAX);
    localparam logic signed [OUT_W-1:0] MIN_V = OUT_W'(SAT_MIN);

    logic signed [OUT_W-1:0] y_s;

    assign y_s = y_i;

    always_comb begin
        y_o   = y_i;
        sat_o = 1'b0;
        if (y_s > MAX_V) begin
            y_o   = MAX_V;
            sat_o = 1'b1;
        end else if (y_s < MIN_V) begin
            y_o   = MIN_V;
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/fir_ctrl_sequencer.sv
// Load/run sequencer in front of the fir_main datapath: routes handshaked bytes
// as coefficients or samples and captures results. Optional clamp: FIR_CTRL_SAT_EN.
module fir_ctrl_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_TAPS = 4,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int FIR_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_load,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] fir_x_n,
    output logic              fir_tvalid,
    output logic              fir_set_coeffs,
    input  logic [OUT_W-1:0]  fir_y_n,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat,
    output logic              coeff_ok,
    output logic              busy
);

    localparam int TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int WAIT_W = (FIR_LAT > 0) ? $clog2(FIR_LAT + 1) : 1;

    localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(NUM_TAPS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(FIR_LAT);

    state_t              state_q;
    logic [TAP_W-1:0]    tap_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic                pend_load_q;
    logic [DATA_W-1:0]   fir_x_n_q;
    logic                fir_tvalid_q;
    logic                fir_set_coeffs_q;
    logic                out_valid_q;
    logic [OUT_W-1:0]    out_data_q;
    logic                out_sat_q;
    logic                coeff_ok_q;
    logic                busy_q;

    logic [OUT_W-1:0]    y_cap;
    logic                sat_cap;

`ifdef FIR_CTRL_SAT_EN
    fir_out_sat #(
        .OUT_W (OUT_W)
    ) u_out_sat (
        .y_i   (fir_y_n),
        .y_o   (y_cap),
        .sat_o (sat_cap)
    );
`else
    assign y_cap   = fir_y_n;
    assign sat_cap = 1'b0;
`endif

    // A pending or current load request takes priority over a sample in RUN.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_LOAD: in_ready = 1'b1;
            ST_RUN:  in_ready = !cmd_load && !pend_load_q;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            tap_cnt_q        <= '0;
            wait_cnt_q       <= '0;
            pend_load_q      <= 1'b0;
            fir_x_n_q        <= '0;
            fir_tvalid_q     <= 1'b0;
            fir_set_coeffs_q <= 1'b0;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_sat_q        <= 1'b0;
            coeff_ok_q       <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            fir_tvalid_q     <= 1'b0;
            fir_set_coeffs_q <= 1'b0;
            out_valid_q      <= 1'b0;
            out_sat_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_load) begin
                        state_q     <= ST_LOAD;
                        busy_q      <= 1'b1;
                        pend_load_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        fir_x_n_q        <= in_data;
                        fir_tvalid_q     <= 1'b1;
                        fir_set_coeffs_q <= 1'b1;
                        if (tap_cnt_q == LAST_TAP) begin
                            tap_cnt_q  <= '0;
                            coeff_ok_q <= 1'b1;
                            state_q    <= ST_RUN;
                            busy_q     <= 1'b0;
                        end else begin
                            tap_cnt_q <= tap_cnt_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cmd_load || pend_load_q) begin
                        state_q     <= ST_LOAD;
                        coeff_ok_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        pend_load_q <= 1'b0;
                    end else if (in_valid) begin
                        fir_x_n_q    <= in_data;
                        fir_tvalid_q <= 1'b1;
                        wait_cnt_q   <= '0;
                        state_q      <= ST_WAIT;
                        busy_q       <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Count starts on the strobe cycle, so capture lands FIR_LAT cycles after it.
                    if (wait_cnt_q == LAST_WAIT) begin
                        out_data_q  <= y_cap;
                        out_sat_q   <= sat_cap;
                        out_valid_q <= 1'b1;
                        wait_cnt_q  <= '0;
                        if (pend_load_q || cmd_load) begin
                            state_q     <= ST_LOAD;
                            coeff_ok_q  <= 1'b0;
                            busy_q      <= 1'b1;
                            pend_load_q <= 1'b0;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                        if (cmd_load) begin
                            pend_load_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fir_x_n        = fir_x_n_q;
    assign fir_tvalid     = fir_tvalid_q;
    assign fir_set_coeffs = fir_set_coeffs_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_sat        = out_sat_q;
    assign coeff_ok       = coeff_ok_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_fir_ctrl_sequencer.sv
// Directed, table-driven bench for fir_ctrl_sequencer (NUM_TAPS=4, FIR_LAT=1),
// with hand-written sequences for load/WAIT interaction, collision and reset.
module tb_fir_ctrl_sequencer;

    localparam int DATA_W = 8;
    localparam int OUT_W  = 11;

`ifdef FIR_CTRL_SAT_EN
    localparam logic [OUT_W-1:0] Y1_EXP   = 11'h07F;
    localparam logic [OUT_W-1:0] YP_EXP   = 11'h07F;
    localparam logic             YP_SAT   = 1'b1;
    localparam logic [OUT_W-1:0] YN_EXP   = 11'h780;
    localparam logic             YN_SAT   = 1'b1;
`else
    localparam logic [OUT_W-1:0] Y1_EXP   = 11'h123;
    localparam logic [OUT_W-1:0] YP_EXP   = 11'h3FF;
    localparam logic             YP_SAT   = 1'b0;
    localparam logic [OUT_W-1:0] YN_EXP   = 11'h400;
    localparam logic             YN_SAT   = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_load = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [DATA_W-1:0] fir_x_n;
    logic              fir_tvalid;
    logic              fir_set_coeffs;
    logic [OUT_W-1:0]  fir_y_n = '0;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;
    logic              coeff_ok;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic              cl;
        logic              iv;
        logic [DATA_W-1:0] d;
        logic [OUT_W-1:0]  y;
        logic              rdy;
        logic              tv;
        logic              sc;
        logic [DATA_W-1:0] x;
        logic              ov;
        logic [OUT_W-1:0]  od;
        logic              ok;
        logic              bsy;
    } vec_t;

    vec_t vecs [12];

    fir_ctrl_sequencer #(
        .NUM_TAPS (4),
        .DATA_W   (DATA_W),
        .OUT_W    (OUT_W),
        .FIR_LAT  (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_load       (cmd_load),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .fir_x_n        (fir_x_n),
        .fir_tvalid     (fir_tvalid),
        .fir_set_coeffs (fir_set_coeffs),
        .fir_y_n        (fir_y_n),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_sat        (out_sat),
        .coeff_ok       (coeff_ok),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; registered outputs are sampled 1 ns after the rising edge.
    task automatic drive(input logic cl, input logic iv, input logic [DATA_W-1:0] d,
                         input logic [OUT_W-1:0] y);
        @(negedge clk);
        cmd_load = cl;
        in_valid = iv;
        in_data  = d;
        fir_y_n  = y;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_coeffs(input logic [DATA_W-1:0] base);
        logic [DATA_W-1:0] b;
        for (int i = 0; i < 4; i++) begin
            b = base + DATA_W'(i);
            drive(1'b0, 1'b1, b, '0);
            chk("load_rdy", in_ready, 1);
            tick;
            chk("load_tvalid", fir_tvalid, 1);
            chk("load_setc", fir_set_coeffs, 1);
            chk("load_x", fir_x_n, b);
            chk("load_ok", coeff_ok, (i == 3) ? 1 : 0);
            $display("coeff byte %0d = %02h coeff_ok=%0b", i, b, coeff_ok);
        end
    endtask

    task automatic run_sample(input logic [DATA_W-1:0] d, input logic [OUT_W-1:0] y,
                              input logic [OUT_W-1:0] exp_od, input logic exp_sat);
        drive(1'b0, 1'b1, d, '0);
        chk("smp_rdy", in_ready, 1);
        tick;
        chk("smp_tvalid", fir_tvalid, 1);
        chk("smp_setc", fir_set_coeffs, 0);
        drive(1'b0, 1'b0, '0, '0);
        tick;
        drive(1'b0, 1'b0, '0, y);
        tick;
        chk("smp_ovalid", out_valid, 1);
        chk("smp_odata", out_data, exp_od);
        chk("smp_sat", out_sat, exp_sat);
        $display("sample %02h y=%03h -> out=%03h sat=%0b", d, y, out_data, out_sat);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 11'h000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'h01, 11'h000, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 11'h000, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 8'h02, 11'h000, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 11'h000, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 8'h03, 11'h000, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 11'h000, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'h04, 11'h000, 1'b1, 1'b1, 1'b1, 8'h04, 1'b0, 11'h000, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h10, 11'h000, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 11'h000, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'h11, 11'h123, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 11'h000, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h11, 11'h123, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, Y1_EXP,  1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h11, 11'h000, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, Y1_EXP,  1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 11'h055, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, Y1_EXP,  1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 11'h055, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 11'h055, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 11'h000, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 11'h055, 1'b1, 1'b0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_tvalid", fir_tvalid, 0);
        chk("rst_x", fir_x_n, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_ok", coeff_ok, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: load 01..04, then two samples with FIR_LAT=1
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].cl, vecs[i].iv, vecs[i].d, vecs[i].y);
            chk("vec_rdy", in_ready, vecs[i].rdy);
            tick;
            chk("vec_tvalid", fir_tvalid, vecs[i].tv);
            chk("vec_setc", fir_set_coeffs, vecs[i].sc);
            chk("vec_x", fir_x_n, vecs[i].x);
            chk("vec_ovalid", out_valid, vecs[i].ov);
            chk("vec_odata", out_data, vecs[i].od);
            chk("vec_ok", coeff_ok, vecs[i].ok);
            chk("vec_busy", busy, vecs[i].bsy);
            $display("vec %0d: rdy=%0b tv=%0b sc=%0b x=%02h ov=%0b od=%03h ok=%0b busy=%0b",
                     i, in_ready, fir_tvalid, fir_set_coeffs, fir_x_n, out_valid, out_data,
                     coeff_ok, busy);
        end

        // Collision: load request wins over an offered sample
        drive(1'b1, 1'b1, 8'h77, '0);
        chk("coll_rdy", in_ready, 0);
        tick;
        chk("coll_tvalid", fir_tvalid, 0);
        chk("coll_busy", busy, 1);
        chk("coll_ok", coeff_ok, 0);
        chk("coll_x", fir_x_n, 8'h11);
        $display("collision: tvalid=%0b busy=%0b coeff_ok=%0b", fir_tvalid, busy, coeff_ok);
        load_coeffs(8'h21);

        // Load requested during WAIT: result still delivered, then LOAD
        drive(1'b0, 1'b1, 8'h30, '0);
        chk("wl_rdy", in_ready, 1);
        tick;
        chk("wl_tvalid", fir_tvalid, 1);
        drive(1'b1, 1'b1, 8'h31, '0);
        chk("wl_rdy_wait", in_ready, 0);
        tick;
        chk("wl_ovalid_early", out_valid, 0);
        drive(1'b0, 1'b0, '0, 11'h040);
        chk("wl_rdy_wait2", in_ready, 0);
        tick;
        chk("wl_ovalid", out_valid, 1);
        chk("wl_odata", out_data, 11'h040);
        chk("wl_busy", busy, 1);
        chk("wl_ok", coeff_ok, 0);
        $display("load-in-wait: out=%03h busy=%0b coeff_ok=%0b", out_data, busy, coeff_ok);
        load_coeffs(8'h41);

        // Saturation corners (pass-through when the clamp is not built)
        run_sample(8'h50, 11'h3FF, YP_EXP, YP_SAT);
        run_sample(8'h51, 11'h400, YN_EXP, YN_SAT);
        run_sample(8'h52, 11'h07F, 11'h07F, 1'b0);

        // Reset in the middle of a coefficient load
        drive(1'b1, 1'b0, '0, '0);
        tick;
        chk("rml_busy", busy, 1);
        drive(1'b0, 1'b1, 8'hA1, '0);
        tick;
        drive(1'b0, 1'b1, 8'hA2, '0);
        tick;
        chk("rml_x_pre", fir_x_n, 8'hA2);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rml_rdy", in_ready, 0);
        chk("rml_tvalid", fir_tvalid, 0);
        chk("rml_setc", fir_set_coeffs, 0);
        chk("rml_x", fir_x_n, 0);
        chk("rml_odata", out_data, 0);
        chk("rml_ok", coeff_ok, 0);
        chk("rml_busy0", busy, 0);
        $display("reset mid-load: x=%02h ok=%0b busy=%0b", fir_x_n, coeff_ok, busy);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'h55, '0);
            chk("idle_rdy", in_ready, 0);
            tick;
            chk("idle_tvalid", fir_tvalid, 0);
            chk("idle_ok", coeff_ok, 0);
            chk("idle_busy", busy, 0);
        end
        drive(1'b1, 1'b0, '0, '0);
        tick;
        load_coeffs(8'hB1);
        run_sample(8'h60, 11'h012, 11'h012, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
